// File: rtl/dds_profile_sequencer.sv
// Timed frequency/phase profile sequencer feeding the DDS phase MAC (A, B, C, E registers).
// Optional late-command counter is built when DDS_LATE_CNT_EN is defined.
module dds_profile_sequencer #(
  parameter int MUL_K = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [47:0] counter,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [47:0] cmd_freq,
  input  logic [13:0] cmd_phase,
  input  logic [47:0] cmd_time,
  input  logic        cmd_continuous,
  output logic [47:0] time_offset,
  output logic [47:0] freq,
  output logic [13:0] phase,
  output logic [47:0] accu_phase,
  output logic        update_pulse,
  output logic        late,
  output logic [15:0] late_cnt
);

  localparam int MUL_CYCLES = 48 / MUL_K;
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT, S_APPLY} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_accept;
  logic          w_mul_step;
  logic          w_mul_done;
  logic          w_apply;

  logic          r_ready;
  logic [47:0]   r_cmd_time;
  logic [47:0]   r_cmd_freq;
  logic [13:0]   r_cmd_phase;
  logic          r_cmd_cont;
  logic [47:0]   r_mcand;
  logic [47:0]   r_mplier;
  logic [47:0]   r_prod;
  logic [CW-1:0] r_mul_cnt;
  logic          r_wait_entry;
  logic          r_late_pend;

  logic [47:0]   r_time_offset;
  logic [47:0]   r_freq;
  logic [13:0]   r_phase;
  logic [47:0]   r_accu;
  logic          r_update;
  logic          r_late;

  logic [47:0]   w_diff;
  logic          w_reached;
  logic          w_past;
  logic [47:0]   w_pp [MUL_K];
  logic [47:0]   w_step_sum;
  logic [47:0]   w_accu_next;

  // Signed distance to the commanded timestamp; mod-2^48 so wrap-around is a forward step.
  assign w_diff    = counter - r_cmd_time;
  assign w_reached = ~w_diff[47];
  assign w_past    = ~w_diff[47] && (w_diff != 48'd0);

  // MUL_K partial products of the shift-add multiplier, one per multiplier bit retired this cycle.
  generate
    for (genvar gi = 0; gi < MUL_K; gi++) begin : g_pp
      assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : 48'd0;
    end
  endgenerate

  always_comb begin
    w_step_sum = 48'd0;
    for (int j = 0; j < MUL_K; j++) begin
      w_step_sum = w_step_sum + w_pp[j];
    end
  end

  assign w_accu_next = r_cmd_cont ? (r_accu + r_prod) : 48'd0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_mul_step   = 1'b0;
    w_mul_done   = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_ready) begin
          w_accept     = 1'b1;
          w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        w_mul_step = 1'b1;
        if (r_mul_cnt == MUL_LAST) begin
          w_mul_done   = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_reached) begin
          w_state_next = S_APPLY;
        end
      end
      S_APPLY: begin
        w_apply      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready       <= 1'b0;
      r_cmd_time    <= 48'd0;
      r_cmd_freq    <= 48'd0;
      r_cmd_phase   <= 14'd0;
      r_cmd_cont    <= 1'b0;
      r_mcand       <= 48'd0;
      r_mplier      <= 48'd0;
      r_prod        <= 48'd0;
      r_mul_cnt     <= '0;
      r_wait_entry  <= 1'b0;
      r_late_pend   <= 1'b0;
      r_time_offset <= 48'd0;
      r_freq        <= 48'd0;
      r_phase       <= 14'd0;
      r_accu        <= 48'd0;
      r_update      <= 1'b0;
      r_late        <= 1'b0;
    end else begin
      r_ready      <= (w_state_next == S_IDLE);
      r_wait_entry <= w_mul_done;
      r_update     <= w_apply;
      // Operands come from the current (old) A/B, which stay frozen until APPLY.
      if (w_accept) begin
        r_cmd_time  <= cmd_time;
        r_cmd_freq  <= cmd_freq;
        r_cmd_phase <= cmd_phase;
        r_cmd_cont  <= cmd_continuous;
        r_mcand     <= cmd_time - r_time_offset;
        r_mplier    <= r_freq;
        r_prod      <= 48'd0;
        r_mul_cnt   <= '0;
        r_late_pend <= 1'b0;
        r_late      <= 1'b0;
      end
      if (w_mul_step) begin
        r_prod    <= r_prod + w_step_sum;
        r_mcand   <= r_mcand << MUL_K;
        r_mplier  <= r_mplier >> MUL_K;
        r_mul_cnt <= r_mul_cnt + 1'b1;
      end
      if ((r_state == S_WAIT) && r_wait_entry && w_past) begin
        r_late_pend <= 1'b1;
      end
      if (w_apply) begin
        r_time_offset <= r_cmd_time;
        r_freq        <= r_cmd_freq;
        r_phase       <= r_cmd_phase;
        r_accu        <= w_accu_next;
        r_late        <= r_late_pend;
      end
    end
  end

`ifdef DDS_LATE_CNT_EN
  logic [15:0] r_late_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_late_cnt <= 16'h0;
    end else if (w_apply && r_late_pend && (r_late_cnt != 16'hFFFF)) begin
      r_late_cnt <= r_late_cnt + 16'h1;
    end
  end

  assign late_cnt = r_late_cnt;
`else
  assign late_cnt = 16'h0;
`endif

  assign cmd_ready    = r_ready;
  assign time_offset  = r_time_offset;
  assign freq         = r_freq;
  assign phase        = r_phase;
  assign accu_phase   = r_accu;
  assign update_pulse = r_update;
  assign late         = r_late;

endmodule

// File: tb/tb_dds_profile_sequencer.sv
// Directed bench for dds_profile_sequencer: table of sequential profile commands plus
// hand-written reset, back-to-back and mid-multiply reset sequences.
module tb_dds_profile_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [47:0] counter;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] cmd_freq;
  logic [13:0] cmd_phase;
  logic [47:0] cmd_time;
  logic        cmd_continuous;
  logic [47:0] time_offset;
  logic [47:0] freq;
  logic [13:0] phase;
  logic [47:0] accu_phase;
  logic        update_pulse;
  logic        late;
  logic [15:0] late_cnt;

  always #5 clk = ~clk;

  dds_profile_sequencer #(.MUL_K(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .counter        (counter),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_freq       (cmd_freq),
    .cmd_phase      (cmd_phase),
    .cmd_time       (cmd_time),
    .cmd_continuous (cmd_continuous),
    .time_offset    (time_offset),
    .freq           (freq),
    .phase          (phase),
    .accu_phase     (accu_phase),
    .update_pulse   (update_pulse),
    .late           (late),
    .late_cnt       (late_cnt)
  );

  typedef struct {
    logic [47:0] cnt;
    logic [47:0] t;
    logic [47:0] freq;
    logic [13:0] ph;
    logic        cont;
    logic [47:0] exp_e;
    logic        exp_late;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_lc  = 0;
  longint unsigned edge_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
    counter  = counter + 48'd1;
    edge_cnt = edge_cnt + 1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] exp_late_cnt();
`ifdef DDS_LATE_CNT_EN
    return 48'(exp_lc);
`else
    return 48'd0;
`endif
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_A"}, time_offset, 48'd0);
    check({tag, "_B"}, freq, 48'd0);
    check({tag, "_C"}, 48'(phase), 48'd0);
    check({tag, "_E"}, accu_phase, 48'd0);
    check({tag, "_pulse"}, 48'(update_pulse), 48'd0);
    check({tag, "_late"}, 48'(late), 48'd0);
    check({tag, "_late_cnt"}, 48'(late_cnt), 48'd0);
  endtask

  // Presents a command with counter preset to cnt; returns the edge count of the accepting edge.
  task automatic issue(input logic [47:0] cnt, input logic [47:0] t, input logic [47:0] f,
                       input logic [13:0] ph, input logic cont, output longint unsigned acc_edge);
    logic rdy;
    logic got;
    got            = 1'b0;
    counter        = cnt;
    cmd_time       = t;
    cmd_freq       = f;
    cmd_phase      = ph;
    cmd_continuous = cont;
    cmd_valid      = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      rdy = cmd_ready;
      step();
      if (rdy) got = 1'b1;
    end
    acc_edge = edge_cnt;
    check("accept_seen", 48'(got), 48'd1);
    cmd_valid      = 1'b0;
    cmd_time       = {$urandom(), $urandom()} ;
    cmd_freq       = {$urandom(), $urandom()} ;
    cmd_phase      = 14'($urandom());
    cmd_continuous = ~cont;
  endtask

  task automatic wait_update(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step();
      if (update_pulse) seen = 1'b1;
    end
  endtask

  initial begin
    longint unsigned acc;
    longint unsigned first_acc;
    longint unsigned second_acc;
    longint unsigned pulse_edge;
    logic seen;
    logic rdy;
    int   pulses;

    vecs[0]  = '{48'd10, 48'd100, 48'h1000, 14'h0, 1'b1, 48'h0, 1'b0};
    vecs[1]  = '{48'd110, 48'd300, 48'h2000, 14'h155, 1'b1, 48'hC8000, 1'b0};
    vecs[2]  = '{48'd310, 48'd400, 48'h3, 14'h3FFF, 1'b0, 48'h0, 1'b0};
    vecs[3]  = '{48'd500, 48'd400, 48'h10, 14'h7, 1'b1, 48'h0, 1'b1};
    vecs[4]  = '{48'd600, 48'd700, 48'h5, 14'h12, 1'b1, 48'h12C0, 1'b0};
    vecs[5]  = '{48'hFFFF_FFFF_FF00, 48'hFFFF_FFFF_FFF0, 48'h1, 14'h0, 1'b0, 48'h0, 1'b0};
    vecs[6]  = '{48'hFFFF_FFFF_FFF8, 48'h10, 48'h1, 14'h3, 1'b1, 48'h20, 1'b0};
    vecs[7]  = '{48'h100, 48'h200, 48'h8000_0000_0001, 14'h1, 1'b1, 48'h210, 1'b0};
    vecs[8]  = '{48'h300, 48'h400, 48'hABCD_EF01_2345, 14'h2AAA, 1'b1, 48'h410, 1'b0};
    vecs[9]  = '{48'h500, 48'h600, 48'h0, 14'h0, 1'b1, 48'h9BDE_0246_8E10, 1'b0};
    vecs[10] = '{48'h1000, 48'h100D, 48'h3, 14'h4, 1'b1, 48'h9BDE_0246_8E10, 1'b0};
    vecs[11] = '{48'h2000, 48'h200C, 48'h55, 14'h5, 1'b1, 48'h9BDE_0246_BE0D, 1'b1};

    resetn = 1'b0; counter = 48'd0; cmd_valid = 1'b0;
    cmd_freq = 48'd0; cmd_phase = 14'd0; cmd_time = 48'd0; cmd_continuous = 1'b0;

    for (int i = 0; i < 5; i++) step();
    check_outputs_zero("reset");
    check("reset_ready", 48'(cmd_ready), 48'd0);
    resetn = 1'b1;
    step();
    check("ready_after_release", 48'(cmd_ready), 48'd1);

    for (int v = 0; v < NV; v++) begin
      issue(vecs[v].cnt, vecs[v].t, vecs[v].freq, vecs[v].ph, vecs[v].cont, acc);
      check("ready_low_busy", 48'(cmd_ready), 48'd0);
      wait_update(seen);
      check("pulse_seen", 48'(seen), 48'd1);
      // APPLY follows the WAIT cycle that sees T; the strobe is visible one cycle later.
      if (vecs[v].exp_late) begin
        exp_lc++;
        check("late_apply_edge", 48'(edge_cnt - acc), 48'd14);
      end else begin
        check("ontime_counter", counter, vecs[v].t + 48'd2);
      end
      check("A", time_offset, vecs[v].t);
      check("B", freq, vecs[v].freq);
      check("C", 48'(phase), 48'(vecs[v].ph));
      check("E", accu_phase, vecs[v].exp_e);
      check("late", 48'(late), 48'(vecs[v].exp_late));
      check("late_cnt", 48'(late_cnt), exp_late_cnt());
      $display("[TB] vec %0d T=0x%0h A=0x%0h B=0x%0h C=0x%0h E=0x%0h late=%0b late_cnt=%0d",
               v, vecs[v].t, time_offset, freq, phase, accu_phase, late, late_cnt);
      step();
      check("pulse_one_cycle", 48'(update_pulse), 48'd0);
    end

    // Back-to-back with cmd_valid held: second accept lands on the cycle after APPLY.
    counter = 48'h3000; cmd_time = 48'h300D; cmd_freq = 48'h10;
    cmd_phase = 14'h9; cmd_continuous = 1'b0; cmd_valid = 1'b1;
    first_acc = 0; second_acc = 0; pulse_edge = 0;
    for (int i = 0; i < 60 && second_acc == 0; i++) begin
      rdy = cmd_ready;
      step();
      if (update_pulse && pulse_edge == 0) pulse_edge = edge_cnt;
      if (rdy) begin
        if (first_acc == 0) first_acc = edge_cnt;
        else second_acc = edge_cnt;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_first_pulse", 48'(pulse_edge - first_acc), 48'd14);
    check("b2b_second_accept", 48'(second_acc - first_acc), 48'd15);
    wait_update(seen);
    exp_lc++;
    check("b2b_pulse2_seen", 48'(seen), 48'd1);
    check("b2b_A", time_offset, 48'h300D);
    check("b2b_E", accu_phase, 48'h0);
    check("b2b_late", 48'(late), 48'd1);
    check("b2b_late_cnt", 48'(late_cnt), exp_late_cnt());
    $display("[TB] b2b accepts %0d cycles apart A=0x%0h late=%0b", second_acc - first_acc, time_offset, late);

    // Reset during cycle 5 of the multiply discards the command.
    issue(48'h5000, 48'h5100, 48'h7, 14'h11, 1'b1, acc);
    for (int i = 0; i < 4; i++) step();
    resetn = 1'b0;
    step();
    check_outputs_zero("midmul_reset");
    check("midmul_reset_ready", 48'(cmd_ready), 48'd0);
    step();
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (update_pulse) pulses++;
    end
    check("midmul_no_pulse", 48'(pulses), 48'd0);
    check("midmul_E_after", accu_phase, 48'd0);
    exp_lc = 0;
    $display("[TB] mid-MUL reset pulses=%0d A=0x%0h E=0x%0h", pulses, time_offset, accu_phase);

    issue(vecs[0].cnt, vecs[0].t, vecs[0].freq, vecs[0].ph, vecs[0].cont, acc);
    wait_update(seen);
    check("rerun_pulse_seen", 48'(seen), 48'd1);
    check("rerun_counter", counter, vecs[0].t + 48'd2);
    check("rerun_A", time_offset, 48'd100);
    check("rerun_B", freq, 48'h1000);
    check("rerun_E", accu_phase, 48'h0);
    check("rerun_late", 48'(late), 48'd0);
    check("rerun_late_cnt", 48'(late_cnt), exp_late_cnt());
    $display("[TB] rerun after reset A=0x%0h B=0x%0h E=0x%0h", time_offset, freq, accu_phase);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
